phase_sequencer: RTL and testbench

//  Run/stall/halt controller for the multicycle CPU's one-hot phase sequence.

---
 rtl/phase_sequencer.sv | 113 +++++++++++
 tb/tb_phase_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Run/stall/halt controller for the multicycle CPU's one-hot phase sequence.
// Drives phase enables to the datapath and counts retired instructions.
module phase_sequencer #(
    parameter int NPHASE    = 6,
    parameter int MEM_PHASE = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              skip_mem,
    input  logic              halt_req,
    input  logic              step_mode,
    input  logic              step,
    output logic [NPHASE-1:0] phase,
    output logic              running,
    output logic              halted,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

    localparam logic [NPHASE-1:0] P1          = NPHASE'(1);
    localparam logic [NPHASE-1:0] P_AFTER_MEM = NPHASE'(1) << (MEM_PHASE + 1);

    state_t            state;
    logic [NPHASE-1:0] ptr;
    logic              ptr_ok;

    assign ptr_ok = (ptr != '0) && ((ptr & (ptr - P1)) == '0);

    // Retirement pulse must coincide with the advancing last-phase cycle, so
    // it is decoded from registered state plus the live stall input.
    assign instr_done = (state == RUN) && ptr_ok && ptr[NPHASE-1] && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= P1;
            phase       <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr <= P1;
                    if (start) begin
                        state   <= RUN;
                        phase   <= P1;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!ptr_ok) begin
                        ptr   <= P1;
                        phase <= P1;
                    end else if (stall) begin
                        ptr   <= ptr;
                    end else if (ptr[NPHASE-1]) begin
                        instr_count <= instr_count + CNT_W'(1);
                        ptr         <= P1;
                        if (halt_req) begin
                            state   <= HALT;
                            phase   <= '0;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end else if (step_mode) begin
                            state   <= PAUSE;
                            phase   <= '0;
                            running <= 1'b0;
                        end else begin
                            phase   <= P1;
                        end
                    end else if (ptr[MEM_PHASE-1] && skip_mem) begin
                        ptr   <= P_AFTER_MEM;
                        phase <= P_AFTER_MEM;
                    end else begin
                        ptr   <= ptr << 1;
                        phase <= ptr << 1;
                    end
                end
                PAUSE: begin
                    ptr <= P1;
                    if (step || !step_mode) begin
                        state   <= RUN;
                        phase   <= P1;
                        running <= 1'b1;
                    end
                end
                HALT: begin
                    ptr <= P1;
                    if (start) begin
                        state   <= RUN;
                        phase   <= P1;
                        running <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ptr     <= P1;
                    phase   <= '0;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: instruction-level plans expand into
// expected per-cycle outputs, a monitor compares them against two instances.
module tb_phase_sequencer;

    localparam int NPH  = 6;
    localparam int MEMP = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic reset, start, stall, skip_mem, halt_req, step_mode, step;

    logic [NPH-1:0] phase_a, phase_b;
    logic           running_a, running_b, halted_a, halted_b, done_a, done_b;
    logic [15:0]    count_a;
    logic [3:0]     count_b;

    phase_sequencer #(.NPHASE(NPH), .MEM_PHASE(MEMP), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .skip_mem(skip_mem), .halt_req(halt_req), .step_mode(step_mode), .step(step),
        .phase(phase_a), .running(running_a), .halted(halted_a),
        .instr_done(done_a), .instr_count(count_a)
    );

    phase_sequencer #(.NPHASE(NPH), .MEM_PHASE(MEMP), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .skip_mem(skip_mem), .halt_req(halt_req), .step_mode(step_mode), .step(step),
        .phase(phase_b), .running(running_b), .halted(halted_b),
        .instr_done(done_b), .instr_count(count_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPH-1:0] phase;
        logic           running;
        logic           halted;
        logic           done;
        logic [15:0]    count;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   model_count = 0;
    int   mode = M_IDLE;
    int   plan_st[NPH];

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            if (phase_a !== e.phase || running_a !== e.running || halted_a !== e.halted ||
                done_a !== e.done || count_a !== e.count ||
                phase_b !== e.phase || running_b !== e.running || halted_b !== e.halted ||
                done_b !== e.done || count_b !== e.count[3:0]) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got phase=%b run=%b halt=%b done=%b cnt=%0d cnt4=%0d | phase4=%b run4=%b halt4=%b done4=%b ; want phase=%b run=%b halt=%b done=%b cnt=%0d cnt4=%0d",
                         $time, phase_a, running_a, halted_a, done_a, count_a, count_b,
                         phase_b, running_b, halted_b, done_b,
                         e.phase, e.running, e.halted, e.done, e.count, e.count[3:0]);
            end
        end
    end

    task automatic push_exp(input logic [NPH-1:0] p, input logic r, input logic h, input logic d);
        exp_t e;
        e.phase   = p;
        e.running = r;
        e.halted  = h;
        e.done    = d;
        e.count   = model_count[15:0];
        expq.push_back(e);
    endtask

    task automatic cyc(input logic i_start, input logic i_stall, input logic i_skip,
                       input logic i_halt, input logic i_smode, input logic i_step,
                       input logic [NPH-1:0] e_phase, input logic e_run,
                       input logic e_halt, input logic e_done);
        @(posedge clk); #1;
        start = i_start; stall = i_stall; skip_mem = i_skip;
        halt_req = i_halt; step_mode = i_smode; step = i_step;
        push_exp(e_phase, e_run, e_halt, e_done);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic void clear_plan();
        for (int i = 0; i < NPH; i++) plan_st[i] = 0;
    endfunction

    // One instruction from P1: phases visited in order, each held for
    // plan_st[p] stall cycles; skip, halt and step_mode only count where sampled.
    task automatic run_instr(input bit sk, input bit hr, input bit sm);
        for (int p = 0; p < NPH; p++) begin
            if (!(sk && p == MEMP)) begin
                for (int s = 0; s <= plan_st[p]; s++) begin
                    bit last_c;
                    logic d_skip, d_halt, d_smode;
                    last_c  = (p == NPH-1) && (s == plan_st[p]);
                    d_skip  = (p == MEMP-1) ? sk : rb();
                    d_halt  = (p == NPH-1)  ? hr : rb();
                    d_smode = (p == NPH-1)  ? sm : rb();
                    cyc(rb(), s < plan_st[p], d_skip, d_halt, d_smode, 1'b0,
                        NPH'(1 << p), 1'b1, 1'b0, last_c);
                    if (last_c) model_count++;
                end
            end
        end
        mode = hr ? M_HALT : (sm ? M_PAUSE : M_RUN);
    endtask

    // Brings the sequencer back to RUN at P1 from whatever state it rests in.
    task automatic resume(input int n);
        case (mode)
            M_IDLE: begin
                for (int i = 0; i < n; i++)
                    cyc(1'b0, rb(), rb(), rb(), rb(), rb(), '0, 1'b0, 1'b0, 1'b0);
                cyc(1'b1, rb(), rb(), rb(), rb(), rb(), '0, 1'b0, 1'b0, 1'b0);
            end
            M_PAUSE: begin
                for (int i = 0; i < n; i++)
                    cyc(1'b0, rb(), rb(), rb(), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
                if (rb()) cyc(1'b0, rb(), rb(), rb(), 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
                else      cyc(1'b0, rb(), rb(), rb(), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            end
            M_HALT: begin
                for (int i = 0; i < n; i++)
                    cyc(1'b0, rb(), rb(), rb(), rb(), rb(), '0, 1'b0, 1'b1, 1'b0);
                cyc(1'b1, rb(), rb(), rb(), rb(), rb(), '0, 1'b0, 1'b1, 1'b0);
            end
            default: ;
        endcase
        mode = M_RUN;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 0; stall = 0; skip_mem = 0;
        halt_req = 0; step_mode = 0; step = 0;
        #12 reset = 1'b0;

        // Idle after reset, control inputs other than start are ignored.
        resume(3);

        // Plain passes: 16 instructions from zero also wraps the 4-bit counter.
        clear_plan();
        for (int i = 0; i < 16; i++) run_instr(0, 0, 0);

        // Memory wait held in P4.
        plan_st[3] = 4;
        run_instr(0, 0, 0);
        clear_plan();

        // Memory phase skipped.
        run_instr(1, 0, 0);

        // HALT, then resume with start.
        run_instr(0, 1, 0);
        resume(3);

        // Single-step mode, stalls in PAUSE ignored.
        run_instr(0, 0, 1);
        resume(4);
        run_instr(0, 0, 1);
        resume(2);
        run_instr(0, 0, 0);

        // Asynchronous reset in P3 abandons the instruction and clears count.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPH'(1), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPH'(2), 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        model_count = 0;
        push_exp('0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp('0, 1'b0, 1'b0, 1'b0);
        mode = M_IDLE;

        // Randomised instruction mix.
        for (int n = 0; n < 40; n++) begin
            bit sk, hr, sm;
            if (mode != M_RUN) resume($urandom_range(0, 3));
            for (int p = 0; p < NPH; p++)
                plan_st[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            sk = ($urandom_range(0, 3) == 0);
            hr = ($urandom_range(0, 7) == 0);
            sm = ($urandom_range(0, 3) == 0);
            run_instr(sk, hr, sm);
        end

        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
